apb_wide_mem_bridge: RTL

APB_WIDE_MEM_BRIDGE -- requirements
Module: apb_wide_mem_bridge

---
 rtl/apb_bridge_pkg.sv | 19 +
 rtl/apb_bridge_lane_buf.sv | 36 +++
 rtl/apb_wide_mem_bridge.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types and sizing helpers for the APB wide-to-narrow memory bridge.
// Optional byte strobes are enabled with the APB_BRIDGE_STRB_EN macro.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } bridge_state_t;

    function automatic int beats_of(input int data_w, input int mem_w);
        return data_w / mem_w;
    endfunction

    function automatic int idx_w(input int data_w, input int mem_w);
        return (data_w / mem_w > 1) ? $clog2(data_w / mem_w) : 1;
    endfunction

endpackage

// File: rtl/apb_bridge_lane_buf.sv
// DATA_W-wide holding buffer with a full parallel load and an
// indexed MEM_W lane write and read port.
module apb_bridge_lane_buf
    import apb_bridge_pkg::*;
#(
    parameter int DATA_W = 128,
    parameter int MEM_W  = 8,
    parameter int IW     = idx_w(DATA_W, MEM_W)
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              lane_we,
    input  logic [IW-1:0]     idx,
    input  logic [MEM_W-1:0]  lane_wdata,
    output logic [MEM_W-1:0]  lane_rdata,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] data_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= load_data;
        end else if (lane_we) begin
            data_q[idx*MEM_W +: MEM_W] <= lane_wdata;
        end
    end

    assign lane_rdata = data_q[idx*MEM_W +: MEM_W];
    assign q          = data_q;

endmodule

// File: rtl/apb_wide_mem_bridge.sv
// Splits one wide APB access into BEATS narrow memory beats.
// Define APB_BRIDGE_STRB_EN to add PSTRB/mem_be and skip empty write beats.
module apb_wide_mem_bridge
    import apb_bridge_pkg::*;
#(
    parameter int  ADDR_W = 4,
    parameter int  DATA_W = 128,
    parameter int  MEM_W  = 8,
    localparam int BEATS  = beats_of(DATA_W, MEM_W),
    localparam int IW     = idx_w(DATA_W, MEM_W)
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [ADDR_W-1:0]    PADDR,
    input  logic [DATA_W-1:0]    PWDATA,
`ifdef APB_BRIDGE_STRB_EN
    input  logic [DATA_W/8-1:0]  PSTRB,
    output logic [MEM_W/8-1:0]   mem_be,
`endif
    output logic [DATA_W-1:0]    PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_W+IW-1:0] mem_addr,
    output logic [MEM_W-1:0]     mem_wdata,
    input  logic [MEM_W-1:0]     mem_rdata,
    input  logic                 mem_ready,
    input  logic                 mem_err
);

    bridge_state_t     state;
    logic [IW-1:0]     beat;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic              err_q;

    logic              setup;
    logic              skip;
    logic              beat_done;
    logic              err_hit;
    logic              last_beat;
    logic [MEM_W-1:0]  wlane;
    logic [MEM_W-1:0]  rlane;
    logic [DATA_W-1:0] wbuf_q;
    logic [DATA_W-1:0] rbuf_q;
    logic              unused_ok;

    assign setup = (state == IDLE) && PSEL && !PENABLE;

`ifdef APB_BRIDGE_STRB_EN
    localparam int BE_W = MEM_W / 8;

    logic [DATA_W/8-1:0] strb_q;
    logic [BE_W-1:0]     lane_strb;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            strb_q <= '0;
        end else if (setup) begin
            strb_q <= PSTRB;
        end
    end

    assign lane_strb = strb_q[beat*BE_W +: BE_W];
    // An all-zero write lane costs one idle cycle and never touches memory
    assign skip      = (state == XFER) && we_q && (lane_strb == '0);
    assign mem_be    = mem_cs ? (we_q ? lane_strb : '1) : '0;
`else
    assign skip = 1'b0;
`endif

    assign beat_done = (state == XFER) && (skip || mem_ready);
    assign err_hit   = (state == XFER) && !skip && mem_ready && mem_err;
    assign last_beat = (beat == IW'(BEATS - 1));

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state  <= IDLE;
            beat   <= '0;
            addr_q <= '0;
            we_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (setup) begin
                        addr_q <= PADDR;
                        we_q   <= PWRITE;
                        beat   <= '0;
                        err_q  <= 1'b0;
                        state  <= XFER;
                    end
                end
                XFER: begin
                    if (beat_done) begin
                        if (err_hit) begin
                            err_q <= 1'b1;
                            state <= DONE;
                        end else if (last_beat) begin
                            state <= DONE;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    apb_bridge_lane_buf #(
        .DATA_W (DATA_W),
        .MEM_W  (MEM_W),
        .IW     (IW)
    ) u_wbuf (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .load       (setup),
        .load_data  (PWDATA),
        .lane_we    (1'b0),
        .idx        (beat),
        .lane_wdata ('0),
        .lane_rdata (wlane),
        .q          (wbuf_q)
    );

    apb_bridge_lane_buf #(
        .DATA_W (DATA_W),
        .MEM_W  (MEM_W),
        .IW     (IW)
    ) u_rbuf (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .load       (1'b0),
        .load_data  ('0),
        .lane_we    ((state == XFER) && !we_q && mem_ready),
        .idx        (beat),
        .lane_wdata (mem_rdata),
        .lane_rdata (rlane),
        .q          (rbuf_q)
    );

    assign unused_ok = ^{wbuf_q, rlane};

    assign mem_cs    = (state == XFER) && !skip;
    assign mem_we    = mem_cs && we_q;
    assign mem_addr  = mem_cs ? {addr_q, beat} : '0;
    assign mem_wdata = mem_cs ? wlane : '0;

    assign PREADY  = (state == DONE);
    assign PSLVERR = (state == DONE) && err_q;
    assign PRDATA  = ((state == DONE) && !err_q && !we_q) ? rbuf_q : '0;

endmodule
